inst_queue: RTL
===============

# inst_queue

Parametrised in-order instruction queue between the decoder and the ROB/dispatch stage, successor to the fixed 16-entry queue. It buffers decoded instructions (op, rs1, rs2, rd, imm) in a circular buffer and presents the oldest entry to dispatch under a valid/ready handshake. Everything runs on a single clock edge. It adds:
- true full/empty tracking with an occupancy count;
- a pipeline flush for branch mispredict;
- an optional empty-queue bypass.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥ 2
- OP_W, 5, opcode width
- REG_W, 5, register index width
- IMM_W, 32, immediate width

Ports:
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  discard all entries
- enq_valid  in  1  decoder presents an instruction
- enq_ready  out  1  queue can accept; equals !full
- enq_op, enq_rs1, enq_rs2, enq_rd, enq_imm  in  OP_W/REG_W/REG_W/REG_W/IMM_W  instruction fields
- deq_valid  out  1  head entry valid
- deq_ready  in  1  dispatch accepts; tie to !rob_full
- deq_op, deq_rs1, deq_rs2, deq_rd, deq_imm  out  OP_W/REG_W/REG_W/REG_W/IMM_W  head entry fields
- count  out  $clog2(DEPTH+1)  current occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- State:
  - head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
  - Payload storage array; not reset.
- Enqueue fires when enq_valid && enq_ready: fields are written at tail, tail+1, count+1.
- Dequeue fires when deq_valid && deq_ready: head+1, count−1.
- Both in the same cycle: both pointers advance and count is unchanged.
- enq_ready depends only on registered state. There is no combinational path from deq_ready, so a full queue refuses an enqueue even when a dequeue fires in the same cycle.
- deq_valid = !empty (plus the bypass case below).
- deq_* are combinational from the entry at head. When deq_valid = 0 they are forced to 0.
- flush has priority over everything: the next state is head = tail = count = 0. Any enqueue or dequeue handshake in the flush cycle has no effect on state.
- Reset values: head = tail = count = 0, enq_ready = 1, full = 0, empty = 1, deq_valid = 0, all deq_* = 0.
- Reset asserted mid-operation clears all state immediately, regardless of clk.

## Timing
- Enqueue-to-visible latency is 1 cycle: an entry written at edge N appears on deq_* after edge N.
- Dequeue takes effect at the edge; the next entry, if any, is presented after that edge.
- count, full and empty are registered-state derived and update at the edge following a handshake.
- Wrap-around: tail = DEPTH−1 followed by an enqueue gives tail = 0. Same for head.
- flush asserted for one cycle → empty = 1 and deq_valid = 0 after the next edge. enq_ready stays 1 throughout.
- Release of rst_n: the queue accepts an enqueue at the first following edge.

## Configuration
- Macro IQ_BYPASS_EN.
- Defined:
  - When empty = 1 and enq_valid = 1, deq_valid = 1 combinationally and deq_* = enq_* in the same cycle.
  - If deq_ready is also 1, the instruction passes straight through: no write, pointers and count unchanged.
  - If deq_ready = 0, it is enqueued normally.
  - flush suppresses the bypass: deq_valid = 0 in a flush cycle.
- Undefined: no combinational enq→deq path; minimum latency is 1 cycle as above.

## Test plan
- Reset then idle → enq_ready = 1, empty = 1, count = 0, deq_valid = 0, deq_imm = 0.
- DEPTH = 16, enqueue 16 entries (imm = 0..15) with deq_ready = 0 → full = 1, enq_ready = 0, count = 16. A 17th enq_valid is ignored.
- From full, hold enq_valid = 1 and deq_ready = 1 → first cycle: dequeue only, count = 15. Thereafter: simultaneous enq/deq, count stays 15. Data emerges as imm 0, 1, 2… in order across pointer wrap.
- Queue holding 5 entries, assert flush together with enq_valid and deq_ready → next cycle count = 0, empty = 1, no entry output or stored.
- Pull rst_n low mid-stream with count = 7, between clock edges → count = 0 and deq_valid = 0 immediately.
- IQ_BYPASS_EN defined, empty queue, enq_valid = 1, deq_ready = 1, imm = 0xDEADBEEF → deq_valid = 1 and deq_imm = 0xDEADBEEF in the same cycle; count remains 0. Undefined: deq_valid rises the next cycle with count = 1.

Source files
------------

// File: rtl/inst_queue.sv
// In-order decoded-instruction queue: circular buffer with occupancy count, flush,
// and valid/ready handshakes. Define IQ_BYPASS_EN to add the empty-queue bypass.
module inst_queue #(
  parameter int DEPTH = 16,
  parameter int OP_W  = 5,
  parameter int REG_W = 5,
  parameter int IMM_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [OP_W-1:0]              enq_op,
  input  logic [REG_W-1:0]             enq_rs1,
  input  logic [REG_W-1:0]             enq_rs2,
  input  logic [REG_W-1:0]             enq_rd,
  input  logic [IMM_W-1:0]             enq_imm,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [OP_W-1:0]              deq_op,
  output logic [REG_W-1:0]             deq_rs1,
  output logic [REG_W-1:0]             deq_rs2,
  output logic [REG_W-1:0]             deq_rd,
  output logic [IMM_W-1:0]             deq_imm,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             enq_entry;
  entry_t             deq_entry;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic               bypass_valid;
  logic               pass_through;
  logic               do_enq;
  logic               do_deq;

  assign enq_entry = {enq_op, enq_rs1, enq_rs2, enq_rd, enq_imm};

  // Status comes only from registered count, so enq_ready never sees deq_ready.
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign enq_ready = !full;

  // NOTE: every signal driven in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    bypass_valid = 1'b0;
`ifdef IQ_BYPASS_EN
    bypass_valid = empty && enq_valid && !flush;
`endif
  end

  assign deq_valid = !empty || bypass_valid;

  always_comb begin
    deq_entry = '0;
    if (!empty)
      deq_entry = mem[head];
    else if (bypass_valid)
      deq_entry = enq_entry;
  end

  assign {deq_op, deq_rs1, deq_rs2, deq_rd, deq_imm} = deq_entry;

  // A bypassed instruction consumed in the same cycle never touches storage.
  assign pass_through = bypass_valid && deq_ready;
  assign do_enq       = enq_valid && enq_ready && !pass_through && !flush;
  assign do_deq       = !empty && deq_ready && !flush;

  // NOTE: payload storage has no reset; only pointers and count decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_enq)
      mem[tail] <= enq_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq)
        tail <= tail + PTR_W'(1);
      if (do_deq)
        head <= head + PTR_W'(1);
      case ({do_enq, do_deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
